// File: rtl/dmem_lsu_responder.sv
// Load/store responder for the core data port: one request per handshake,
// RISC-V funct3 size/sign handling, response after a fixed wait.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, not in reset)
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             store data (byte/half from LSBs)
//   req_mask              funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid/rsp_ready   response handshake, response held until accepted
//   rsp_rdata             extended load data, 0 for stores and errors
//   rsp_err               misaligned, out of range or illegal mask
//   dbg_wr_en             one-cycle pulse when a store commits
//   dbg_wr_addr           byte address of the committed store
//   dbg_wr_data           full merged word written
module dmem_lsu_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dbg_wr_en,
    output logic [31:0] dbg_wr_addr,
    output logic [31:0] dbg_wr_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  mask_q, mask_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        dbg_en_q, dbg_en_d;
    logic [31:0] dbg_addr_q, dbg_addr_d;
    logic [31:0] dbg_data_q, dbg_data_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [4:0]    lane_sh;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          out_of_range;
    logic          mask_bad;
    logic          misalign;
    logic          err;
    logic [31:0]   load_data;
    logic [31:0]   merged;
    logic          commit;
    logic          mem_we;

    assign idx     = addr_q[AW+1:2];
    assign lane_sh = {addr_q[1:0], 3'b000};
    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[lane_sh +: 8];
    assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    assign out_of_range = addr_q[31:2] >= DEPTH_W;

    // Stores have no unsigned variants, so mask[2] is illegal on a store.
    assign mask_bad = (mask_q == 3'b011) || (mask_q == 3'b110)
                   || (mask_q == 3'b111) || (we_q && mask_q[2]);

    always_comb begin
        misalign = 1'b0;
        case (mask_q[1:0])
            2'b01:   misalign = addr_q[0];
            2'b10:   misalign = (addr_q[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    assign err = out_of_range || mask_bad || misalign;

    always_comb begin
        load_data = rd_word;
        case (mask_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merged = rd_word;
        case (mask_q[1:0])
            2'b00: merged[lane_sh +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // WAIT lasts WAIT_CYCLES+1 cycles; the last one is the commit edge.
    assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && !err && !reset;

    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_wr_en   = dbg_en_q;
    assign dbg_wr_addr = dbg_addr_q;
    assign dbg_wr_data = dbg_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        dbg_en_d    = 1'b0;
        dbg_addr_d  = dbg_addr_q;
        dbg_data_d  = dbg_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err;
                    rsp_rdata_d = (err || we_q) ? 32'd0 : load_data;
                    if (we_q && !err) begin
                        dbg_en_d   = 1'b1;
                        dbg_addr_d = addr_q;
                        dbg_data_d = merged;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mask_q      <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            dbg_en_q    <= 1'b0;
            dbg_addr_q  <= 32'd0;
            dbg_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            dbg_en_q    <= dbg_en_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= merged;
    end

endmodule

// File: tb/tb_dmem_lsu_responder.sv
// Directed bench for dmem_lsu_responder with a response scoreboard.
// Expected results are queued at accept and checked at the response.
module tb_dmem_lsu_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_mask = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dbg_wr_en;
    logic [31:0] dbg_wr_addr;
    logic [31:0] dbg_wr_data;

    dmem_lsu_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_wr_addr(dbg_wr_addr),
        .dbg_wr_data(dbg_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        dbg;
        logic [31:0] daddr;
        logic [31:0] ddata;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mism = 0;
    int dbg_cnt = 0;
    logic [31:0] dbg_addr_s = 32'd0;
    logic [31:0] dbg_data_s = 32'd0;

    localparam logic [2:0] MB  = 3'b000;
    localparam logic [2:0] MH  = 3'b001;
    localparam logic [2:0] MW  = 3'b010;
    localparam logic [2:0] MBU = 3'b100;
    localparam logic [2:0] MHU = 3'b101;

    always @(negedge clk) begin
        if (dbg_wr_en === 1'b1) begin
            dbg_cnt++;
            dbg_addr_s = dbg_wr_addr;
            dbg_data_s = dbg_wr_data;
        end
    end

    function automatic exp_t mk(input logic e, input logic [31:0] r,
                                input logic d, input logic [31:0] a,
                                input logic [31:0] w);
        exp_t x;
        x.err = e;
        x.rdata = r;
        x.dbg = d;
        x.daddr = a;
        x.ddata = w;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic we,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [2:0] m, input exp_t e);
        int n = 0;
        @(negedge clk);
        req_we = we;
        req_addr = a;
        req_wdata = w;
        req_mask = m;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        int cyc = 0;
        int d0 = dbg_cnt;
        logic [31:0] r;
        logic er;
        exp_t e;
        while (rsp_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd3);
        r = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, r);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_err"}, {31'd0, er}, {31'd0, e.err});
            chk({tag, "_rdata"}, r, e.rdata);
            chk({tag, "_dbg_cnt"}, 32'(dbg_cnt - d0), {31'd0, e.dbg});
            if (e.dbg) begin
                chk({tag, "_dbg_addr"}, dbg_addr_s, e.daddr);
                chk({tag, "_dbg_data"}, dbg_data_s, e.ddata);
            end
        end
    endtask

    task automatic xact(input string tag, input logic we,
                        input logic [31:0] a, input logic [31:0] w,
                        input logic [2:0] m, input exp_t e);
        issue(tag, we, a, w, m, e);
        collect(tag, 0);
    endtask

    initial begin
        int d0;
        // Reset with a request asserted: the request must be ignored.
        reset = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h10;
        req_mask = MW;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_dbg_en", {31'd0, dbg_wr_en}, 32'd0);
        chk("rst_dbg_addr", dbg_wr_addr, 32'd0);
        chk("rst_dbg_data", dbg_wr_data, 32'd0);
        reset = 1'b0;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_dbg", 32'(dbg_cnt), 32'd0);

        xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, MW,
             mk(0, 0, 1, 32'h10, 32'hDEADBEEF));
        xact("lw10", 1'b0, 32'h10, 32'h0, MW,
             mk(0, 32'hDEADBEEF, 0, 0, 0));
        xact("sb11", 1'b1, 32'h11, 32'h1234567F, MB,
             mk(0, 0, 1, 32'h11, 32'hDEAD7FEF));
        xact("lb13", 1'b0, 32'h13, 32'h0, MB,
             mk(0, 32'hFFFFFFDE, 0, 0, 0));
        xact("lbu11", 1'b0, 32'h11, 32'h0, MBU,
             mk(0, 32'h0000007F, 0, 0, 0));
        xact("lw10b", 1'b0, 32'h10, 32'h0, MW,
             mk(0, 32'hDEAD7FEF, 0, 0, 0));
        xact("lh12", 1'b0, 32'h12, 32'h0, MH,
             mk(0, 32'hFFFFDEAD, 0, 0, 0));
        xact("lhu12", 1'b0, 32'h12, 32'h0, MHU,
             mk(0, 32'h0000DEAD, 0, 0, 0));
        xact("lh11", 1'b0, 32'h11, 32'h0, MH,
             mk(1, 0, 0, 0, 0));
        xact("sw402", 1'b1, 32'h402, 32'hCAFEF00D, MW,
             mk(1, 0, 0, 0, 0));
        xact("sw400", 1'b1, 32'h400, 32'hCAFEF00D, MW,
             mk(1, 0, 0, 0, 0));
        xact("lw400", 1'b0, 32'h400, 32'h0, MW,
             mk(1, 0, 0, 0, 0));
        xact("ld_m011", 1'b0, 32'h10, 32'h0, 3'b011,
             mk(1, 0, 0, 0, 0));
        xact("st_m100", 1'b1, 32'h10, 32'h0, MBU,
             mk(1, 0, 0, 0, 0));
        xact("lw10c", 1'b0, 32'h10, 32'h0, MW,
             mk(0, 32'hDEAD7FEF, 0, 0, 0));
        xact("sw14", 1'b1, 32'h14, 32'h11223344, MW,
             mk(0, 0, 1, 32'h14, 32'h11223344));
        xact("sh16", 1'b1, 32'h16, 32'h9876CAFE, MH,
             mk(0, 0, 1, 32'h16, 32'hCAFE3344));
        xact("lw14", 1'b0, 32'h14, 32'h0, MW,
             mk(0, 32'hCAFE3344, 0, 0, 0));
        xact("lb14", 1'b0, 32'h14, 32'h0, MB,
             mk(0, 32'h00000044, 0, 0, 0));

        // Back-pressure: response held, a queued request must wait.
        issue("hold1", 1'b0, 32'h10, 32'h0, MW,
              mk(0, 32'hDEAD7FEF, 0, 0, 0));
        req_we = 1'b0;
        req_addr = 32'h14;
        req_mask = MHU;
        req_valid = 1'b1;
        collect("hold1", 5);
        chk("hold2_accept", {31'd0, req_ready}, 32'd1);
        sb.push_back(mk(0, 32'h00003344, 0, 0, 0));
        @(negedge clk);
        req_valid = 1'b0;
        collect("hold2", 0);

        // Reset during WAIT aborts the store.
        xact("sw20", 1'b1, 32'h20, 32'h55, MW,
             mk(0, 0, 1, 32'h20, 32'h55));
        d0 = dbg_cnt;
        issue("sw20_abort", 1'b1, 32'h20, 32'h1, MW,
              mk(0, 0, 1, 32'h20, 32'h1));
        reset = 1'b1;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        for (int i = 0; i < 6; i++) begin
            chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("abort_dbg", 32'(dbg_cnt - d0), 32'd0);
        xact("lw20", 1'b0, 32'h20, 32'h0, MW,
             mk(0, 32'h55, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
